arashi_thread_arbiter: RTL and testbench

- Round-robin read arbiter that drains NUM_THREADS per-thread caches into one ordered output stream tagged with thread id.
- Sits directly downstream of the per-thread caches: consumes their avail/data_out, drives their r_ena, feeds the downstream consumer over valid/ready.
- Issue is credit-limited so nothing popped from a cache is ever dropped under backpressure.

---
 rtl/arashi_thread_arbiter.sv | 106 ++++++++++
 tb/tb_arashi_thread_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arashi_thread_arbiter.sv
// Round-robin drain of NUM_THREADS thread caches into one tid-tagged stream.
// Issue is credit-limited against the output FIFO so backpressure never drops a popped entry.
module arashi_thread_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_DEPTH   = 4,
    parameter int TID_WIDTH   = $clog2(NUM_THREADS)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_THREADS-1:0]            avail,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_THREADS-1:0]            r_ena,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [TID_WIDTH-1:0]              out_tid
);
    localparam int STAGES = 2;
    localparam int PW     = $clog2(OUT_DEPTH);
    localparam int CW     = PW + 1;

    typedef struct packed {
        logic [TID_WIDTH-1:0]  tid;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [TID_WIDTH-1:0] rr_ptr, win, s1_tid, s2_tid;
    logic [STAGES:1]      vld_pipe;   // [1] = issue (s1), [2] = capture (s2)
    logic                 found, grant, credit_ok;
    logic [CW:0]          used;

    entry_t               mem [OUT_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 push, pop;

    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        for (int k = 0; k < NUM_THREADS; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_THREADS;
            if (!found && avail[idx]) begin
                found = 1'b1;
                win   = TID_WIDTH'(idx);
            end
        end
    end

    // Entries in flight count against the FIFO; a same-cycle pop is deliberately not credited.
    assign used      = (CW+1)'(cnt) + (CW+1)'(vld_pipe[1]) + (CW+1)'(vld_pipe[2]);
    assign credit_ok = used < (CW+1)'(OUT_DEPTH);
    assign grant     = found && credit_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ena    <= '0;
            vld_pipe <= '0;
            s1_tid   <= '0;
            s2_tid   <= '0;
            rr_ptr   <= '0;
        end else begin
            r_ena    <= grant ? (NUM_THREADS'(1) << win) : '0;
            vld_pipe <= {vld_pipe[1], grant};
            s1_tid   <= win;
            s2_tid   <= s1_tid;
            if (grant)
                rr_ptr <= (win == TID_WIDTH'(NUM_THREADS-1)) ? '0 : win + TID_WIDTH'(1);
        end
    end

    assign push      = vld_pipe[2];
    assign out_valid = (cnt != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{tid: s2_tid, data: data_in[int'(s2_tid)*DATA_WIDTH +: DATA_WIDTH]};
    end

    // Empty FIFO presents zeros so reset drives the head to 0 without clearing storage.
    assign out_data = out_valid ? mem[rd_ptr].data : '0;
    assign out_tid  = out_valid ? mem[rd_ptr].tid  : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && cnt == CW'(OUT_DEPTH)));
    a_rena_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(r_ena));

endmodule

// File: tb/tb_arashi_thread_arbiter.sv
// Bench for arashi_thread_arbiter: cache models feed the DUT, a scoreboard checks the output stream.
module tb_arashi_thread_arbiter;
    localparam int NT = 4;
    localparam int DW = 32;
    localparam int TW = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [NT-1:0]    avail, r_ena;
    logic [NT*DW-1:0] data_in;
    logic             out_valid, out_ready;
    logic [DW-1:0]    out_data;
    logic [TW-1:0]    out_tid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TW-1:0] tid;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    arashi_thread_arbiter #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .OUT_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .avail(avail), .data_in(data_in), .r_ena(r_ena),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tid(out_tid)
    );

    // Cache model: registered read, avail already discounts this cycle's pop.
    logic [DW-1:0] cmem [NT][32];
    int            wr_idx [NT];
    int            rd_idx [NT];
    logic [DW-1:0] dout   [NT];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NT; i++) begin
                rd_idx[i] <= 0;
                dout[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NT; i++)
                if (r_ena[i]) begin
                    dout[i]   <= cmem[i][rd_idx[i] % 32];
                    rd_idx[i] <= rd_idx[i] + 1;
                end
        end
    end

    always_comb begin
        avail   = '0;
        data_in = '0;
        for (int i = 0; i < NT; i++) begin
            avail[i]            = (wr_idx[i] - rd_idx[i]) > int'(r_ena[i]);
            data_in[i*DW +: DW] = dout[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int t, input logic [DW-1:0] d);
        cmem[t][wr_idx[t] % 32] = d;
        wr_idx[t] = wr_idx[t] + 1;
    endtask

    task automatic expect_out(input int t, input logic [DW-1:0] d);
        exp_t e;
        e.tid  = TW'(t);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int i = 0; i < NT; i++) wr_idx[i] = 0;
        sb.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_stream: got tid=%0d data=%h, expected nothing", out_tid, out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_tid !== e.tid || out_data !== e.data) begin
                        errors++;
                        $display("FAIL out_stream: got tid=%0d data=%h, expected tid=%0d data=%h",
                                 out_tid, out_data, e.tid, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (r_ena !== 4'b0)    begin errors++; $display("FAIL reset_rena: got %b want 0000", r_ena); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0)   begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_tid !== '0)    begin errors++; $display("FAIL reset_tid: got %0d want 0", out_tid); end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_single();
        tick();
        load(0, 32'hA5A5_0001);
        expect_out(0, 32'hA5A5_0001);
        @(negedge clk);
        checks++; if (r_ena !== 4'b0000) begin errors++; $display("FAIL single_T_rena: got %b want 0000", r_ena); end
        @(negedge clk);
        checks++; if (r_ena !== 4'b0001) begin errors++; $display("FAIL single_T1_rena: got %b want 0001", r_ena); end
        @(negedge clk);
        checks++; if (r_ena !== 4'b0000 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_T2: got rena=%b valid=%b want 0000/0", r_ena, out_valid);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || out_tid !== 2'd0) begin
            errors++; $display("FAIL single_T3: got valid=%b data=%h tid=%0d want 1/a5a50001/0", out_valid, out_data, out_tid);
        end
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_drain: %0d outputs missing, want 0", sb.size()); end
    endtask

    task automatic test_all_rr();
        logic [3:0] er;
        do_reset();
        tick();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NT; i++) begin
                load(i, 32'hB000_0000 | (i << 8) | k);
                expect_out(i, 32'hB000_0000 | (i << 8) | k);
            end
        @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            er = 4'(1 << (j % 4));
            checks++; if (r_ena !== er) begin errors++; $display("FAIL rr_rena[%0d]: got %b want %b", j, r_ena, er); end
            if (j >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_bubble[%0d]: got valid=%b want 1", j, out_valid); end
            end
        end
        @(negedge clk);
        checks++; if (r_ena !== 4'b0) begin errors++; $display("FAIL rr_idle: got %b want 0000", r_ena); end
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rr_drain: %0d outputs missing, want 0", sb.size()); end
    endtask

    task automatic test_wrap();
        logic [3:0] er;
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            load(0, 32'hC000_0000 | k); expect_out(0, 32'hC000_0000 | k);
            load(3, 32'hC300_0000 | k); expect_out(3, 32'hC300_0000 | k);
        end
        @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            er = (j % 2 == 1) ? 4'b1000 : 4'b0001;
            checks++; if (r_ena !== er) begin errors++; $display("FAIL wrap_rena[%0d]: got %b want %b", j, r_ena, er); end
        end
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d outputs missing, want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic [3:0] er;
        do_reset();
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NT; i++) begin
                load(i, 32'hD000_0000 | (i << 8) | k);
                expect_out(i, 32'hD000_0000 | (i << 8) | k);
            end
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            er = (j < 4) ? 4'(1 << j) : 4'b0000;
            checks++; if (r_ena !== er) begin errors++; $display("FAIL bp_rena[%0d]: got %b want %b", j, r_ena, er); end
            if (j >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 32'hD000_0000 || out_tid !== 2'd0) begin
                    errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h tid=%0d want 1/d0000000/0", j, out_valid, out_data, out_tid);
                end
            end
        end
        tick();
        out_ready = 1'b1;
        for (int n = 0; n < 8 && r_ena == 4'b0; n++) @(negedge clk);
        checks++; if (r_ena !== 4'b0001) begin errors++; $display("FAIL bp_resume: got %b want 0001", r_ena); end
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: %0d outputs missing, want 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] er;
        tick();
        for (int k = 0; k < 3; k++) begin
            load(2, 32'hE200_0000 + 32'(k * 17));
            expect_out(2, 32'hE200_0000 + 32'(k * 17));
        end
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            er = (j < 3) ? 4'b0100 : 4'b0000;
            checks++; if (r_ena !== er) begin errors++; $display("FAIL b2b_rena[%0d]: got %b want %b", j, r_ena, er); end
        end
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d outputs missing, want 0", sb.size()); end
    endtask

    // Pointer sits at 3 on entry, so the post-reset grant to thread 0 shows the pointer was cleared.
    task automatic test_reset_mid();
        logic [3:0] seq [4];
        seq[0] = 4'b1000; seq[1] = 4'b0001; seq[2] = 4'b0010; seq[3] = 4'b0100;
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < NT; i++) load(i, 32'hF000_0000 | i);
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++; if (r_ena !== seq[j]) begin errors++; $display("FAIL rmid_rena[%0d]: got %b want %b", j, r_ena, seq[j]); end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
        #2 rstn = 1'b0;
        for (int i = 0; i < NT; i++) wr_idx[i] = 0;
        sb.delete();
        #1;
        checks++; if (r_ena !== 4'b0 || out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL rmid_async: got rena=%b valid=%b data=%h want 0000/0/0", r_ena, out_valid, out_data);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++; if (r_ena !== 4'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL rmid_idle[%0d]: got rena=%b valid=%b want 0000/0", j, r_ena, out_valid);
            end
        end
        tick();
        for (int i = 0; i < NT; i++) begin
            load(i, 32'h9000_0000 | i);
            expect_out(i, 32'h9000_0000 | i);
        end
        @(negedge clk);
        @(negedge clk);
        checks++; if (r_ena !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant: got %b want 0001", r_ena); end
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmid_drain: %0d outputs missing, want 0", sb.size()); end
    endtask

    initial begin
        out_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_all_rr();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
